rv_dm_host_arb: RTL and testbench



---
 rtl/rv_dm_host_arb.sv | 148 ++++++++++++++
 tb/tb_rv_dm_host_arb.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rv_dm_host_arb.sv
// rtl/rv_dm_host_arb.sv - round-robin arbiter sharing the debug module system-bus host port
module rv_dm_host_arb #(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumReq-1:0]        req_i,
  input  logic [NumReq*BusWidth-1:0] addr_i,
  input  logic [NumReq-1:0]        we_i,
  input  logic [NumReq*BusWidth-1:0] wdata_i,
  input  logic [NumReq*BusWidth/8-1:0] be_i,
  output logic [NumReq-1:0]        gnt_o,
  output logic [NumReq-1:0]        rvalid_o,
  output logic [BusWidth-1:0]      rdata_o,
  output logic                     err_o,
  output logic                     host_req_o,
  output logic [BusWidth-1:0]      host_addr_o,
  output logic                     host_we_o,
  output logic [BusWidth-1:0]      host_wdata_o,
  output logic [BusWidth/8-1:0]    host_be_o,
  input  logic                     host_gnt_i,
  input  logic                     host_rvalid_i,
  input  logic [BusWidth-1:0]      host_rdata_i,
  input  logic                     host_err_i,
  output logic                     busy_o,
  output logic                     timeout_o
);

  localparam int unsigned BeW  = BusWidth / 8;
  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDrain
  } state_e;

  state_e            state_q;
  logic [IdxW-1:0]   owner_q;
  logic [IdxW-1:0]   rr_ptr_q;
  logic [CntW-1:0]   cnt_q;

  logic [IdxW-1:0]   winner;
  logic              any_req;
  logic [IdxW-1:0]   next_ptr;
  logic [NumReq-1:0] owner_oh;
  logic              owner_req;
  logic              rsp_hit;
  logic              tmo_hit;

  // Round-robin pick: first requester at or above rr_ptr, otherwise the lowest one below it
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (!any_req && req_i[i] && (i >= int'(rr_ptr_q))) begin
        any_req = 1'b1;
        winner  = IdxW'(i);
      end
    end
    for (int i = 0; i < NumReq; i++) begin
      if (!any_req && req_i[i]) begin
        any_req = 1'b1;
        winner  = IdxW'(i);
      end
    end
  end

  // Response/watchdog decode; a real response in the last watchdog cycle beats the timeout
  always_comb begin
    next_ptr  = (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + 1'b1;
    owner_oh  = NumReq'(1) << owner_q;
    owner_req = req_i[owner_q];
    rsp_hit   = (state_q == StWait) && host_rvalid_i;
    tmo_hit   = (TimeoutCycles != 0) && (state_q == StWait) && !host_rvalid_i &&
                (cnt_q == CntW'(TimeoutCycles - 1));
  end

  // Transaction FSM: one request in flight, owner remembered for response routing
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_req) begin
            owner_q <= winner;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (!owner_req) begin
            state_q <= StIdle;
          end else if (host_gnt_i) begin
            rr_ptr_q <= next_ptr;
            cnt_q    <= '0;
            state_q  <= StWait;
          end
        end
        StWait: begin
          if (host_rvalid_i) begin
            state_q <= StIdle;
          end else if (tmo_hit) begin
            state_q <= StDrain;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDrain: begin
          // The late response belongs to an abandoned transaction and is swallowed here
          if (host_rvalid_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output decode: payload muxed from the owner only while requesting, responses passed through
  always_comb begin
    host_req_o   = (state_q == StReq);
    host_addr_o  = '0;
    host_we_o    = 1'b0;
    host_wdata_o = '0;
    host_be_o    = '0;
    if (state_q == StReq) begin
      host_addr_o  = addr_i[owner_q*BusWidth +: BusWidth];
      host_we_o    = we_i[owner_q];
      host_wdata_o = wdata_i[owner_q*BusWidth +: BusWidth];
      host_be_o    = be_i[owner_q*BeW +: BeW];
    end
    gnt_o     = (host_req_o && owner_req && host_gnt_i) ? owner_oh : '0;
    rvalid_o  = (rsp_hit || tmo_hit) ? owner_oh : '0;
    rdata_o   = rsp_hit ? host_rdata_i : '0;
    err_o     = rsp_hit ? host_err_i : tmo_hit;
    timeout_o = tmo_hit;
    busy_o    = (state_q != StIdle);
  end

endmodule

// File: tb/tb_rv_dm_host_arb.sv
// tb/tb_rv_dm_host_arb.sv - table-driven bench for rv_dm_host_arb
module tb_rv_dm_host_arb;

  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h2000_0000;
  localparam logic [31:0] W0 = 32'h0BAD_0000;
  localparam logic [31:0] W1 = 32'hCAFE_F00D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0;
  logic [63:0] addr;
  logic [1:0]  we;
  logic [63:0] wdata;
  logic [7:0]  be;
  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata;
  logic        err, host_req, host_we, busy, timeout;
  logic [31:0] host_addr, host_wdata;
  logic [3:0]  host_be;
  logic        host_gnt = 1'b0, host_rvalid = 1'b0, host_err = 1'b0;
  logic [31:0] host_rdata = '0;

  int n_vec = 0;
  int n_err = 0;

  assign addr  = {A1, A0};
  assign we    = 2'b10;
  assign wdata = {W1, W0};
  assign be    = 8'hC3;

  always #5 clk = ~clk;

  rv_dm_host_arb #(.NumReq(2), .BusWidth(32), .TimeoutCycles(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .we_i(we), .wdata_i(wdata),
    .be_i(be), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .host_req_o(host_req), .host_addr_o(host_addr), .host_we_o(host_we),
    .host_wdata_o(host_wdata), .host_be_o(host_be), .host_gnt_i(host_gnt),
    .host_rvalid_i(host_rvalid), .host_rdata_i(host_rdata), .host_err_i(host_err),
    .busy_o(busy), .timeout_o(timeout)
  );

  typedef struct {
    logic [1:0]  req;
    logic        hgnt;
    logic        hrv;
    logic [31:0] hrdata;
    logic        herr;
    logic [1:0]  gnt;
    logic [1:0]  rv;
    logic [31:0] rdata;
    logic        err;
    logic        hreq;
    logic [31:0] haddr;
    logic        hwe;
    logic        busy;
    logic        tmo;
  } vec_t;

  function automatic vec_t mk(logic [1:0] rq, logic hg, logic hr, logic [31:0] hd, logic he,
                              logic [1:0] g, logic [1:0] r, logic [31:0] d, logic e,
                              logic q, logic [31:0] a, logic w, logic b, logic t);
    vec_t v;
    v.req = rq; v.hgnt = hg; v.hrv = hr; v.hrdata = hd; v.herr = he;
    v.gnt = g; v.rv = r; v.rdata = d; v.err = e; v.hreq = q; v.haddr = a;
    v.hwe = w; v.busy = b; v.tmo = t;
    return v;
  endfunction

  // Shorthands: quiet idle cycle, and a waiting cycle with nothing happening
  function automatic vec_t idle(logic [1:0] rq);
    return mk(rq, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic vec_t waitq(logic [1:0] rq);
    return mk(rq, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic [31:0] ewd;
    logic [3:0]  ebe;
    @(negedge clk);
    req = v.req; host_gnt = v.hgnt; host_rvalid = v.hrv;
    host_rdata = v.hrdata; host_err = v.herr;
    #1;
    ewd = (v.haddr == A0) ? W0 : (v.haddr == A1) ? W1 : 32'h0;
    ebe = (v.haddr == A0) ? 4'h3 : (v.haddr == A1) ? 4'hC : 4'h0;
    n_vec++;
    chk({tag, ".gnt"},    32'(gnt),      32'(v.gnt));
    chk({tag, ".rvalid"}, 32'(rvalid),   32'(v.rv));
    chk({tag, ".rdata"},  rdata,         v.rdata);
    chk({tag, ".err"},    32'(err),      32'(v.err));
    chk({tag, ".hreq"},   32'(host_req), 32'(v.hreq));
    chk({tag, ".haddr"},  host_addr,     v.haddr);
    chk({tag, ".hwe"},    32'(host_we),  32'(v.hwe));
    chk({tag, ".hwdata"}, host_wdata,    ewd);
    chk({tag, ".hbe"},    32'(host_be),  32'(ebe));
    chk({tag, ".busy"},   32'(busy),     32'(v.busy));
    chk({tag, ".tmo"},    32'(timeout),  32'(v.tmo));
  endtask

  task automatic chk_zero(input string tag);
    n_vec++;
    chk({tag, ".gnt"},    32'(gnt),      0);
    chk({tag, ".rvalid"}, 32'(rvalid),   0);
    chk({tag, ".rdata"},  rdata,         0);
    chk({tag, ".err"},    32'(err),      0);
    chk({tag, ".hreq"},   32'(host_req), 0);
    chk({tag, ".haddr"},  host_addr,     0);
    chk({tag, ".busy"},   32'(busy),     0);
    chk({tag, ".tmo"},    32'(timeout),  0);
  endtask

  vec_t tbl[25];

  initial begin
    // single read, round-robin pairs, spurious responses, write with error, dropped request
    tbl[0]  = idle(2'b01);
    tbl[1]  = mk(2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, A0, 0, 1, 0);
    tbl[2]  = mk(2'b01, 1, 0, 0, 0, 2'b01, 2'b00, 0, 0, 1, A0, 0, 1, 0);
    tbl[3]  = waitq(2'b00);
    tbl[4]  = mk(2'b00, 0, 1, 32'hDEAD_BEEF, 0, 2'b00, 2'b01, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 0);
    tbl[5]  = idle(2'b00);
    tbl[6]  = idle(2'b11);
    tbl[7]  = mk(2'b11, 1, 0, 0, 0, 2'b10, 2'b00, 0, 0, 1, A1, 1, 1, 0);
    tbl[8]  = mk(2'b11, 0, 1, 32'h1111_1111, 0, 2'b00, 2'b10, 32'h1111_1111, 0, 0, 0, 0, 1, 0);
    tbl[9]  = idle(2'b11);
    tbl[10] = mk(2'b11, 1, 0, 0, 0, 2'b01, 2'b00, 0, 0, 1, A0, 0, 1, 0);
    tbl[11] = mk(2'b11, 0, 1, 32'h2222_2222, 0, 2'b00, 2'b01, 32'h2222_2222, 0, 0, 0, 0, 1, 0);
    tbl[12] = idle(2'b11);
    tbl[13] = mk(2'b11, 1, 0, 0, 0, 2'b10, 2'b00, 0, 0, 1, A1, 1, 1, 0);
    tbl[14] = mk(2'b11, 0, 1, 32'h3333_3333, 0, 2'b00, 2'b10, 32'h3333_3333, 0, 0, 0, 0, 1, 0);
    tbl[15] = idle(2'b11);
    tbl[16] = mk(2'b11, 1, 0, 0, 0, 2'b01, 2'b00, 0, 0, 1, A0, 0, 1, 0);
    tbl[17] = mk(2'b00, 0, 1, 32'h4444_4444, 0, 2'b00, 2'b01, 32'h4444_4444, 0, 0, 0, 0, 1, 0);
    tbl[18] = mk(2'b10, 0, 1, 32'h5A5A_5A5A, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    tbl[19] = mk(2'b10, 1, 1, 32'h5A5A_5A5A, 1, 2'b10, 2'b00, 0, 0, 1, A1, 1, 1, 0);
    tbl[20] = mk(2'b00, 0, 1, 32'h0, 1, 2'b00, 2'b10, 0, 1, 0, 0, 0, 1, 0);
    tbl[21] = idle(2'b00);
    tbl[22] = idle(2'b01);
    tbl[23] = mk(2'b00, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, A0, 0, 1, 0);
    tbl[24] = idle(2'b00);

    // reset state with busy-looking inputs driven
    req = 2'b11; host_gnt = 1'b1; host_rvalid = 1'b1; host_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    req = '0; host_gnt = 1'b0; host_rvalid = 1'b0; host_rdata = '0;
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) apply(tbl[i], $sformatf("v%0d", i));

    // watchdog: owner 0 granted, no response for 8 cycles, late response drained
    apply(idle(2'b01), "t3.idle");
    apply(mk(2'b01, 1, 0, 0, 0, 2'b01, 2'b00, 0, 0, 1, A0, 0, 1, 0), "t3.gnt");
    for (int i = 0; i < 7; i++) apply(waitq(2'b00), $sformatf("t3.w%0d", i));
    apply(mk(2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 0, 1, 0, 0, 0, 1, 1), "t3.tmo");
    for (int i = 0; i < 3; i++) apply(waitq(2'b10), $sformatf("t3.drain%0d", i));
    apply(mk(2'b10, 0, 1, 32'h5555_5555, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0), "t3.late");
    apply(idle(2'b10), "t3.idle2");
    // response arriving exactly in the final watchdog cycle wins
    apply(mk(2'b10, 1, 0, 0, 0, 2'b10, 2'b00, 0, 0, 1, A1, 1, 1, 0), "t6.gnt");
    for (int i = 0; i < 7; i++) apply(waitq(2'b00), $sformatf("t6.w%0d", i));
    apply(mk(2'b00, 0, 1, 32'h6666_6666, 0, 2'b00, 2'b10, 32'h6666_6666, 0, 0, 0, 0, 1, 0),
          "t6.rsp");
    apply(idle(2'b00), "t6.idle");

    // reset during WAIT: outputs clear, in-flight response becomes spurious, rr_ptr back to 0
    apply(idle(2'b01), "t5.idle");
    apply(mk(2'b01, 1, 0, 0, 0, 2'b01, 2'b00, 0, 0, 1, A0, 0, 1, 0), "t5.gnt");
    apply(waitq(2'b00), "t5.wait");
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("t5.rst");
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(2'b00, 0, 1, 32'h7777_7777, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0), "t5.spur");
    apply(idle(2'b11), "t5.idle2");
    apply(mk(2'b11, 1, 0, 0, 0, 2'b01, 2'b00, 0, 0, 1, A0, 0, 1, 0), "t5.gnt2");
    apply(mk(2'b00, 0, 1, 32'h8888_8888, 0, 2'b00, 2'b01, 32'h8888_8888, 0, 0, 0, 0, 1, 0),
          "t5.rsp");
    apply(idle(2'b00), "t5.end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
